// File: rtl/uart_8n1_core.sv
// uart_8n1_core: 8N1 UART transmitter plus 16x-oversampled receiver.
// Optional internal loopback (tx -> receiver) when UART_LOOPBACK_EN is defined.
module uart_8n1_core #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    input  logic       rx,
`ifdef UART_LOOPBACK_EN
    input  logic       loopback,
`endif
    output logic       rdy,
    input  logic       rdy_clr,
    output logic [7:0] dout
);
    localparam int TX_DIV = CLK_HZ / BAUD;
    localparam int RX_DIV = CLK_HZ / (16 * BAUD);
    localparam int TXW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
    localparam int RXW = (RX_DIV > 1) ? $clog2(RX_DIV) : 1;
    localparam logic [TXW-1:0] TX_LAST = TXW'(TX_DIV - 1);
    localparam logic [RXW-1:0] RX_LAST = RXW'(RX_DIV - 1);

    typedef enum logic [1:0] {
        T_IDLE, T_START, T_DATA, T_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE, R_START, R_DATA, R_STOP
    } rx_state_t;

    tx_state_t      tx_state, tx_state_n;
    logic [TXW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]     tx_bit, tx_bit_n;
    logic [7:0]     tx_sh, tx_sh_n;
    logic           tx_q, tx_q_n;
    logic           tx_busy_n;
    logic           tx_end;

    rx_state_t      rx_state, rx_state_n;
    logic [RXW-1:0] rx_div;
    logic           rx_tick;
    logic           rx_s1, rx_s2;
    logic           rx_src;
    logic [3:0]     rx_tcnt, rx_tcnt_n;
    logic [2:0]     rx_bit, rx_bit_n;
    logic [7:0]     rx_sh, rx_sh_n;
    logic           rx_armed, rx_armed_n;
    logic           rx_done;
    logic [7:0]     dout_n;
    logic           rdy_n;

`ifdef UART_LOOPBACK_EN
    assign tx     = loopback ? 1'b1 : tx_q;
    assign rx_src = loopback ? tx_q : rx;
`else
    assign tx     = tx_q;
    assign rx_src = rx;
`endif

    assign tx_end = (tx_cnt == TX_LAST);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_q     <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_q     <= tx_q_n;
            tx_busy  <= tx_busy_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_q_n     = tx_q;
        tx_busy_n  = tx_busy;
        if (tx_state != T_IDLE) begin
            tx_cnt_n = tx_end ? '0 : tx_cnt + TXW'(1);
        end
        unique case (tx_state)
            T_IDLE: begin
                if (wr_en) begin
                    tx_state_n = T_START;
                    tx_sh_n    = din;
                    tx_cnt_n   = '0;
                    tx_q_n     = 1'b0;
                    tx_busy_n  = 1'b1;
                end
            end
            T_START: begin
                if (tx_end) begin
                    tx_state_n = T_DATA;
                    tx_bit_n   = '0;
                    tx_q_n     = tx_sh[0];
                end
            end
            T_DATA: begin
                if (tx_end) begin
                    if (tx_bit == 3'd7) begin
                        tx_state_n = T_STOP;
                        tx_q_n     = 1'b1;
                    end else begin
                        tx_bit_n = tx_bit + 3'd1;
                        tx_sh_n  = {1'b0, tx_sh[7:1]};
                        tx_q_n   = tx_sh[1];
                    end
                end
            end
            T_STOP: begin
                if (tx_end) begin
                    tx_state_n = T_IDLE;
                    tx_busy_n  = 1'b0;
                    tx_q_n     = 1'b1;
                end
            end
        endcase
    end

    // Synchronizer idles high so reset never looks like a start bit.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx_src;
            rx_s2 <= rx_s1;
        end
    end

    assign rx_tick = (rx_div == RX_LAST);

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_div <= '0;
        end else begin
            rx_div <= rx_tick ? '0 : rx_div + RXW'(1);
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= R_IDLE;
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_armed <= 1'b0;
            dout     <= '0;
            rdy      <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_tcnt  <= rx_tcnt_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
            rx_armed <= rx_armed_n;
            dout     <= dout_n;
            rdy      <= rdy_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_tcnt_n  = rx_tcnt;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_armed_n = rx_armed;
        dout_n     = dout;
        rx_done    = 1'b0;
        if (rx_tick) begin
            unique case (rx_state)
                R_IDLE: begin
                    // A start bit only counts once the line has been seen high.
                    if (rx_armed && !rx_s2) begin
                        rx_state_n = R_START;
                        rx_tcnt_n  = '0;
                        rx_armed_n = 1'b0;
                    end else if (rx_s2) begin
                        rx_armed_n = 1'b1;
                    end
                end
                R_START: begin
                    if (rx_tcnt == 4'd7) begin
                        rx_tcnt_n  = '0;
                        rx_bit_n   = '0;
                        rx_state_n = rx_s2 ? R_IDLE : R_DATA;
                    end else begin
                        rx_tcnt_n = rx_tcnt + 4'd1;
                    end
                end
                R_DATA: begin
                    if (rx_tcnt == 4'd15) begin
                        rx_tcnt_n = '0;
                        rx_sh_n   = {rx_s2, rx_sh[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state_n = R_STOP;
                        end else begin
                            rx_bit_n = rx_bit + 3'd1;
                        end
                    end else begin
                        rx_tcnt_n = rx_tcnt + 4'd1;
                    end
                end
                R_STOP: begin
                    if (rx_tcnt == 4'd15) begin
                        rx_tcnt_n  = '0;
                        rx_state_n = R_IDLE;
                        if (rx_s2) begin
                            dout_n  = rx_sh;
                            rx_done = 1'b1;
                        end
                    end else begin
                        rx_tcnt_n = rx_tcnt + 4'd1;
                    end
                end
            endcase
        end
        rdy_n = rdy;
        if (rdy_clr) begin
            rdy_n = 1'b0;
        end
        if (rx_done) begin
            rdy_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_8n1_core.sv
// tb_uart_8n1_core: directed plus randomized check of uart_8n1_core
// against a time-based frame model of the serial line.
`timescale 1ns/1ps
module tb_uart_8n1_core;
    localparam int CLK_HZ = 1600;
    localparam int BAUD   = 100;
    localparam int BITC   = 16;

    logic       clk_50m = 1'b0;
    logic       rst_n   = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] din     = 8'h00;
    logic       rx      = 1'b1;
    logic       rdy_clr = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       rdy;
    logic [7:0] dout;
`ifdef UART_LOOPBACK_EN
    logic       loopback = 1'b0;
`endif

    uart_8n1_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk_50m (clk_50m),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .din     (din),
        .tx      (tx),
        .tx_busy (tx_busy),
        .rx      (rx),
`ifdef UART_LOOPBACK_EN
        .loopback(loopback),
`endif
        .rdy     (rdy),
        .rdy_clr (rdy_clr),
        .dout    (dout)
    );

    always #5 clk_50m = ~clk_50m;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // TX model: clocks elapsed since the accepted request.
    int         tx_t = -1;
    logic [7:0] tx_byte = 8'h00;
    // RX model: a completed frame may land anywhere in a short window.
    logic       m_rdy = 1'b0;
    logic [7:0] m_dout = 8'h00;
    int         win = 0;
    logic [7:0] win_dout = 8'h00;
    int         req_seq = 0;
    int         ack_seq = 0;
    logic [7:0] req_dout = 8'h00;
    int         lat_meas = 3;

    function automatic logic frame_bit(input int t, input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        return f[t / BITC];
    endfunction

    always @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            tx_t   = -1;
            m_rdy  = 1'b0;
            m_dout = 8'h00;
            win    = 0;
        end else begin
            if (tx_t < 0) begin
                if (wr_en) begin
                    tx_t    = 0;
                    tx_byte = din;
                end
            end else begin
                tx_t++;
                if (tx_t == 10 * BITC) tx_t = -1;
            end
            if (win > 0) begin
                win--;
                if (win == 0) begin
                    m_rdy  = 1'b1;
                    m_dout = win_dout;
                end else if (rdy_clr) begin
                    m_rdy = 1'b0;
                end
            end else if (rdy_clr) begin
                m_rdy = 1'b0;
            end
            if (req_seq != ack_seq) begin
                ack_seq  = req_seq;
                win      = 3;
                win_dout = req_dout;
            end
        end
    end

    always @(negedge clk_50m) begin
        chk("tx_busy", tx_busy, tx_t >= 0);
        chk("tx", tx, (tx_t < 0) ? 1'b1 : frame_bit(tx_t, tx_byte));
        if (win == 0) begin
            chk("rdy", rdy, m_rdy);
            chk("dout", dout, m_dout);
        end
    end

    task automatic send_tx(input logic [7:0] b);
        @(negedge clk_50m);
        wr_en = 1'b1;
        din   = b;
        @(negedge clk_50m);
        wr_en = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stp,
                           input int clr_t, input logic meas);
        logic [9:0] f;
        logic       got;
        f   = {stp, b, 1'b0};
        got = 1'b0;
        for (int t = 0; t < 10 * BITC; t++) begin
            @(negedge clk_50m);
            rx      = f[t / BITC];
            rdy_clr = (t == clr_t);
            if (t == 152 && stp) begin
                req_dout = b;
                req_seq++;
            end
            if (meas && !got && t > 152 && rdy === 1'b1) begin
                lat_meas = t - 152;
                got      = 1'b1;
            end
        end
        rdy_clr = 1'b0;
        if (meas) begin
            chk("rdy_latency", got && lat_meas >= 1 && lat_meas <= 3, 1);
        end
        if (!stp) begin
            @(negedge clk_50m);
            rx = 1'b1;
            repeat (24) @(negedge clk_50m);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_50m);
    endtask

    task automatic rand_tx();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_50m);
            wr_en = 1'b1;
            din   = 8'($urandom);
            repeat ($urandom_range(1, 200)) begin
                @(negedge clk_50m);
                din = 8'($urandom);
            end
            wr_en = 1'b0;
            idle($urandom_range(0, 170));
        end
    endtask

    task automatic rand_rx();
        int kind;
        for (int i = 0; i < 14; i++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 6) begin
                send_rx(8'($urandom), 1'b1,
                        $urandom_range(0, 1) ? $urandom_range(20, 130) : -1,
                        1'b0);
                idle($urandom_range(0, 10));
            end else if (kind <= 8) begin
                send_rx(8'($urandom), 1'b0, -1, 1'b0);
            end else begin
                @(negedge clk_50m);
                rx = 1'b0;
                idle($urandom_range(1, 6));
                rx = 1'b1;
                idle(30);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] seq;
        logic [9:0] fr;
        seq = 10'b1101001010;

        idle(4);
        chk("reset_tx", tx, 1);
        chk("reset_busy", tx_busy, 0);
        chk("reset_rdy", rdy, 0);
        chk("reset_dout", dout, 8'h00);
        rst_n = 1'b1;
        idle(20);
        chk("post_reset_tx", tx, 1);

        @(negedge clk_50m);
        wr_en = 1'b1;
        din   = 8'hA5;
        @(negedge clk_50m);
        wr_en = 1'b0;
        chk("a5_busy_rise", tx_busy, 1);
        for (int t = 1; t <= 160; t++) begin
            @(negedge clk_50m);
            if (t == 40) begin
                wr_en = 1'b1;
                din   = 8'h3C;
            end
            if (t == 41) wr_en = 1'b0;
            if (t % BITC == 8) chk("a5_bit", tx, seq[t / BITC]);
            if (t == 159) chk("a5_busy_159", tx_busy, 1);
            if (t == 160) chk("a5_busy_160", tx_busy, 0);
        end
        idle(40);
        chk("a5_idle_tx", tx, 1);
        chk("a5_idle_busy", tx_busy, 0);

        send_rx(8'h5A, 1'b1, -1, 1'b1);
        idle(4);
        chk("rx5a_rdy", rdy, 1);
        chk("rx5a_dout", dout, 8'h5A);
        @(negedge clk_50m);
        rdy_clr = 1'b1;
        @(negedge clk_50m);
        rdy_clr = 1'b0;
        chk("clr_rdy", rdy, 0);
        chk("clr_dout", dout, 8'h5A);

        @(negedge clk_50m);
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(40);
        chk("glitch_rdy", rdy, 0);

        send_rx(8'hFF, 1'b0, -1, 1'b0);
        chk("frame_err_rdy", rdy, 0);
        chk("frame_err_dout", dout, 8'h5A);

        send_rx(8'h11, 1'b1, -1, 1'b0);
        send_rx(8'h22, 1'b1, -1, 1'b0);
        idle(4);
        chk("overrun_rdy", rdy, 1);
        chk("overrun_dout", dout, 8'h22);

        send_rx(8'h33, 1'b1, 152 + lat_meas - 1, 1'b0);
        idle(4);
        chk("race_rdy", rdy, 1);
        chk("race_dout", dout, 8'h33);

        fr = {1'b1, 8'h69, 1'b0};
        @(negedge clk_50m);
        wr_en = 1'b1;
        din   = 8'h96;
        rx    = 1'b0;
        for (int t = 1; t <= 72; t++) begin
            @(negedge clk_50m);
            wr_en = 1'b0;
            rx    = fr[t / BITC];
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_tx", tx, 1);
        chk("mid_reset_busy", tx_busy, 0);
        chk("mid_reset_rdy", rdy, 0);
        rx = 1'b1;
        idle(3);
        rst_n = 1'b1;
        idle(30);

        fork
            send_tx(8'hC3);
            send_rx(8'hC3, 1'b1, -1, 1'b0);
        join
        idle(20);
        chk("c3_rdy", rdy, 1);
        chk("c3_dout", dout, 8'hC3);
        chk("c3_tx_done", tx_busy, 0);

        fork
            rand_tx();
            rand_rx();
        join
        idle(400);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
